shift_pattern_detector: RTL and testbench

- Parametrised successor to the button-driven pattern shift register.
- Holds a WIDTH-bit pattern register, loaded one bit at a time from debounced button levels; supports both shift directions and a tick-driven auto-rotate mode.
- Detects a programmed PATTERN and counts matches.
- Sits between the debounce block and the LED/FND output logic; consumes the shared tickGen tick.

---
 rtl/shift_pattern_detector.sv | 124 ++++++++++++
 tb/tb_shift_pattern_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pattern_detector.sv
// shift_pattern_detector
// Holds a WIDTH-bit pattern register that is loaded one bit at a time from
// debounced button levels. The register can also auto-rotate on tickGen ticks
// or be frozen. The block flags each hit of PATTERN once the register has been
// completely filled, and keeps a saturating count of those hits.
module shift_pattern_detector #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'b1011_0001),
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             btnOne,
    input  logic             btnZero,
    input  logic             btnClr,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] shiftReg,
    output logic             full,
    output logic             match,
    output logic [CNT_W-1:0] matchCnt
);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;

    localparam int               FILL_W   = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic              oneQ;
    logic              zeroQ;
    logic              clrQ;
    logic              oneRise;
    logic              zeroRise;
    logic              clrRise;

    logic [FILL_W-1:0] fillCnt;
    logic [FILL_W-1:0] fillNext;
    logic [WIDTH-1:0]  regNext;
    logic              anyEvent;
    logic              fullNext;
    logic              hit;

    assign oneRise  = btnOne  & ~oneQ;
    assign zeroRise = btnZero & ~zeroQ;
    assign clrRise  = btnClr  & ~clrQ;

    // Remember the previous button levels so a held button produces one rise.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oneQ  <= 1'b0;
            zeroQ <= 1'b0;
            clrQ  <= 1'b0;
        end else begin
            oneQ  <= btnOne;
            zeroQ <= btnZero;
            clrQ  <= btnClr;
        end
    end

    // Work out the next register and fill values for this cycle's event.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        regNext  = shiftReg;
        fillNext = fillCnt;
        anyEvent = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                // Both data buttons rising together is ambiguous: drop it.
                if (oneRise ^ zeroRise) begin
                    anyEvent = 1'b1;
                    regNext  = dir ? {shiftReg[WIDTH-2:0], oneRise}
                                   : {oneRise, shiftReg[WIDTH-1:1]};
                    if (fillCnt != FILL_MAX) begin
                        fillNext = fillCnt + 1'b1;
                    end
                end
            end
            MODE_ROTATE: begin
                if (tick) begin
                    anyEvent = 1'b1;
                    regNext  = dir ? {shiftReg[WIDTH-2:0], shiftReg[WIDTH-1]}
                                   : {shiftReg[0], shiftReg[WIDTH-1:1]};
                end
            end
            default: begin
                // Hold: register and fill level stay frozen.
            end
        endcase
    end

    assign fullNext = (fillNext == FILL_MAX);
    assign hit      = anyEvent & (regNext == PATTERN) & fullNext;
    assign full     = (fillCnt == FILL_MAX);

    // Update the pattern register, fill level, match pulse and hit counter;
    // a clear edge overrides whatever the current mode would do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            fillCnt  <= '0;
            match    <= 1'b0;
            matchCnt <= '0;
        end else if (clrRise) begin
            shiftReg <= '0;
            fillCnt  <= '0;
            match    <= 1'b0;
            matchCnt <= '0;
        end else begin
            shiftReg <= regNext;
            fillCnt  <= fillNext;
            match    <= hit;
            if (hit && (matchCnt != CNT_MAX)) begin
                matchCnt <= matchCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_pattern_detector.sv
// tb_shift_pattern_detector
// Directed bench: button presses and ticks are applied on the falling edge,
// results are sampled on the following falling edge, and every expected value
// is a hand-computed constant.
module tb_shift_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       btnOne;
    logic       btnZero;
    logic       btnClr;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] shiftReg;
    logic       full;
    logic       match;
    logic [1:0] matchCnt;

    int checks = 0;
    int errors = 0;

    shift_pattern_detector #(
        .WIDTH  (8),
        .PATTERN(8'b1011_0001),
        .CNT_W  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .btnOne  (btnOne),
        .btnZero (btnZero),
        .btnClr  (btnClr),
        .dir     (dir),
        .mode    (mode),
        .shiftReg(shiftReg),
        .full    (full),
        .match   (match),
        .matchCnt(matchCnt)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle button pulse; returns on the falling edge where the result is visible.
    task automatic btnPulse(input logic o, input logic z, input logic c);
        @(negedge clk);
        btnOne  = o;
        btnZero = z;
        btnClr  = c;
        @(negedge clk);
        btnOne  = 1'b0;
        btnZero = 1'b0;
        btnClr  = 1'b0;
    endtask

    task automatic enterBit(input logic b);
        btnPulse(b, ~b, 1'b0);
    endtask

    // Enter bits[n-1] first, bits[0] last.
    task automatic loadBits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            enterBit(bits[i]);
        end
    endtask

    task automatic tickPulse();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        btnOne  = 1'b0;
        btnZero = 1'b0;
        btnClr  = 1'b0;
        dir     = 1'b1;
        mode    = 2'b00;

        // Reset held while buttons toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btnOne  = ~btnOne;
            btnZero = btnOne;
            tick    = ~tick;
        end
        check("rst_reg", 32'(shiftReg), 0);
        check("rst_cnt", 32'(matchCnt), 0);
        check("rst_match", 32'(match), 0);
        check("rst_full", 32'(full), 0);

        // Release with buttons low: nothing happens.
        @(negedge clk);
        btnOne  = 1'b0;
        btnZero = 1'b0;
        tick    = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_reg", 32'(shiftReg), 0);
        check("rel_cnt", 32'(matchCnt), 0);

        // Button held through reset release yields exactly one rise.
        @(negedge clk);
        rst_n  = 1'b0;
        btnOne = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btnOne = 1'b0;
        check("held_rise_reg", 32'(shiftReg), 'h01);
        check("held_rise_full", 32'(full), 0);
        @(negedge clk);
        check("held_rise_once", 32'(shiftReg), 'h01);
        btnPulse(1'b0, 1'b0, 1'b1);
        check("clr0_reg", 32'(shiftReg), 0);

        // Manual load, dir=1.
        mode = 2'b00;
        dir  = 1'b1;
        loadBits(8'b0101_1000, 7);
        check("m1_7bits_reg", 32'(shiftReg), 'h58);
        check("m1_7bits_full", 32'(full), 0);
        check("m1_7bits_match", 32'(match), 0);
        enterBit(1'b1);
        check("m1_reg", 32'(shiftReg), 'hB1);
        check("m1_full", 32'(full), 1);
        check("m1_match", 32'(match), 1);
        check("m1_cnt", 32'(matchCnt), 1);
        @(negedge clk);
        check("m1_match_1cyc", 32'(match), 0);
        enterBit(1'b0);
        check("m1_9th_reg", 32'(shiftReg), 'h62);
        check("m1_9th_match", 32'(match), 0);
        check("m1_9th_cnt", 32'(matchCnt), 1);

        // Clear.
        btnPulse(1'b0, 1'b0, 1'b1);
        check("clr1_reg", 32'(shiftReg), 0);
        check("clr1_cnt", 32'(matchCnt), 0);
        check("clr1_full", 32'(full), 0);

        // Manual load, dir=0: 1,0,0,0,1,1,0,1.
        dir = 1'b0;
        loadBits(8'b1000_1101, 8);
        check("m0_reg", 32'(shiftReg), 'hB1);
        check("m0_full", 32'(full), 1);
        check("m0_match", 32'(match), 1);
        check("m0_cnt", 32'(matchCnt), 1);

        // Simultaneous edges ignored; 7 bits aligned by rotation do not match.
        btnPulse(1'b0, 1'b0, 1'b1);
        dir = 1'b1;
        loadBits(8'b0011_0001, 6);
        check("p_6bits_reg", 32'(shiftReg), 'h31);
        btnPulse(1'b1, 1'b1, 1'b0);
        check("both_reg", 32'(shiftReg), 'h31);
        check("both_match", 32'(match), 0);
        enterBit(1'b1);
        check("p_7bits_reg", 32'(shiftReg), 'h63);
        check("p_7bits_full", 32'(full), 0);
        mode = 2'b01;
        dir  = 1'b0;
        tickPulse();
        check("p_align_reg", 32'(shiftReg), 'hB1);
        check("p_align_nomatch", 32'(match), 0);
        check("p_align_cnt", 32'(matchCnt), 0);
        mode = 2'b00;
        dir  = 1'b1;
        enterBit(1'b0);
        check("p_8th_reg", 32'(shiftReg), 'h62);
        check("p_8th_full", 32'(full), 1);
        check("p_8th_match", 32'(match), 0);

        // Auto rotate, dir=1, 8 ticks.
        btnPulse(1'b0, 1'b0, 1'b1);
        loadBits(8'b1011_0001, 8);
        check("r_load_cnt", 32'(matchCnt), 1);
        mode = 2'b01;
        dir  = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tickPulse();
            if (t == 1) check("r_tick1_reg", 32'(shiftReg), 'h63);
            check($sformatf("r_tick%0d_match", t), 32'(match), (t == 8) ? 1 : 0);
        end
        check("r_back_reg", 32'(shiftReg), 'hB1);
        check("r_cnt", 32'(matchCnt), 2);
        btnPulse(1'b1, 1'b0, 1'b0);
        check("r_btn1_reg", 32'(shiftReg), 'hB1);
        btnPulse(1'b0, 1'b1, 1'b0);
        check("r_btn0_reg", 32'(shiftReg), 'hB1);
        check("r_btn_match", 32'(match), 0);

        // Hold modes.
        mode = 2'b10;
        repeat (3) tickPulse();
        check("h10_reg", 32'(shiftReg), 'hB1);
        check("h10_match", 32'(match), 0);
        mode = 2'b11;
        tickPulse();
        enterBit(1'b0);
        check("h11_reg", 32'(shiftReg), 'hB1);

        // Counter saturation: three more full rotations, five hits in total.
        mode = 2'b01;
        for (int r = 0; r < 3; r++) begin
            dir = r[0];
            for (int t = 1; t <= 8; t++) begin
                tickPulse();
                if (t == 8) check($sformatf("sat_r%0d_match", r), 32'(match), 1);
            end
            check($sformatf("sat_r%0d_cnt", r), 32'(matchCnt), 3);
        end

        // Clear wins over a simultaneous one-edge in manual mode.
        mode = 2'b00;
        dir  = 1'b1;
        btnPulse(1'b1, 1'b0, 1'b1);
        check("clrwin_reg", 32'(shiftReg), 0);
        check("clrwin_cnt", 32'(matchCnt), 0);
        check("clrwin_full", 32'(full), 0);
        check("clrwin_match", 32'(match), 0);

        // Asynchronous reset mid-operation acts without a clock edge.
        enterBit(1'b1);
        check("pre_arst_reg", 32'(shiftReg), 'h01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_reg", 32'(shiftReg), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
